// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a byte stream (length, big-endian words[, checksum]) and holds the CPU in reset until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int INST_SIZE = 16,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_wr_en,
    output logic [ADDR_SIZE-1:0] mem_wr_addr,
    output logic [INST_SIZE-1:0] mem_wr_data,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int BPI = INST_SIZE / 8;
    localparam int BW = BPI > 1 ? $clog2(BPI) : 1;

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, WRITE, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CHECK;
`else
    localparam state_t FIN = DONE;
`endif

    state_t state, next;
    logic [ADDR_SIZE-1:0] addr;
    logic [7:0] rem;
    logic [BW-1:0] bcnt;
    logic [INST_SIZE-1:0] asm_r, asm_next;
    logic acc, last_byte, len_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xsum;
`endif

    assign acc = in_valid && in_ready;
    assign last_byte = bcnt == BW'(BPI - 1);
    assign asm_next = INST_SIZE'({asm_r, in_data});
    assign len_bad = {1'b0, in_data} > (9'd1 << ADDR_SIZE);

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next = LEN;
            LEN:   if (acc) next = in_data == 8'd0 ? FIN : len_bad ? ERROR : DATA;
            DATA:  if (acc && last_byte) next = WRITE;
            WRITE: next = rem == 8'd1 ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (acc) next = in_data == xsum ? DONE : ERROR;
`endif
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == LEN || state == DATA;
`ifdef LOADER_CHECKSUM_EN
        in_ready  = in_ready || state == CHECK;
`endif
        mem_wr_en = state == WRITE;
        cpu_rst   = state != DONE;
        done      = state == DONE;
        error     = state == ERROR;
        busy      = !(state == IDLE || state == DONE || state == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            rem         <= '0;
            bcnt        <= '0;
            asm_r       <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            xsum        <= '0;
`endif
        end else begin
            if (start && !busy) begin
                addr <= '0;
                bcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                xsum <= '0;
`endif
            end
            if (state == LEN && acc)
                rem <= in_data;
`ifdef LOADER_CHECKSUM_EN
            if ((state == LEN || state == DATA) && acc)
                xsum <= xsum ^ in_data;
`endif
            // write port is latched when the word completes so it holds outside WRITE
            if (state == DATA && acc) begin
                asm_r <= asm_next;
                bcnt  <= last_byte ? '0 : bcnt + 1'b1;
                if (last_byte) begin
                    mem_wr_addr <= addr;
                    mem_wr_data <= asm_next;
                end
            end
            if (state == WRITE) begin
                addr <= addr + 1'b1;
                rem  <= rem - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven cycle vectors plus directed multi-cycle sequences for program_loader.
module tb_program_loader;
    logic clk = 0, rst, start, in_valid;
    logic [7:0] in_data;
    logic in_ready, mem_wr_en, cpu_rst, busy, done, error;
    logic [7:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    int checks = 0, failures = 0;
    logic [23:0] wq[$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_wr_en) wq.push_back({mem_wr_addr, mem_wr_data});

    typedef struct {
        logic st, v;
        logic [7:0] d;
        logic rdy, we;
        logic [7:0] a;
        logic [15:0] wd;
        logic cpu, bsy, dn, er;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic rdy, logic we, logic [7:0] a,
                                logic [15:0] wd, logic cpu, logic bsy, logic dn, logic er);
        vec_t x;
        x.st = st; x.v = v; x.d = d; x.rdy = rdy; x.we = we; x.a = a; x.wd = wd;
        x.cpu = cpu; x.bsy = bsy; x.dn = dn; x.er = er;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit toggle);
        bit ok = 0;
        if (toggle) begin
            in_valid = 0;
            @(posedge clk); #1;
        end
        in_valid = 1;
        in_data = b;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit toggle);
        foreach (s[i]) send(s[i], toggle);
    endtask

    task automatic wait_end(input string n, input logic dn, input logic er);
        bit hit = 0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(negedge clk);
            hit = done || error;
        end
        chk({n, "_done"}, done, dn);
        chk({n, "_error"}, error, er);
        chk({n, "_cpu_rst"}, cpu_rst, !dn);
        chk({n, "_busy"}, busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_two_writes(input string n);
        chk({n, "_nwr"}, wq.size(), 2);
        if (wq.size() >= 2) begin
            chk({n, "_w0"}, wq[0], 24'h00_1234);
            chk({n, "_w1"}, wq[1], 24'h01_ABCD);
        end
    endtask

    logic [7:0] strm[$];

    initial begin
        rst = 1; start = 0; in_valid = 0; in_data = 0;
        repeat (2) @(posedge clk); #1;
        rst = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_cpu_rst", cpu_rst, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_error", error, 0);
        chk("idle_ready", in_ready, 0);
        chk("idle_addr", mem_wr_addr, 0);
        chk("idle_data", mem_wr_data, 0);
        chk("idle_nwr", wq.size(), 0);
        @(posedge clk); #1;

        // cycle-exact load of 02 12 34 AB CD, byte held valid through WRITE, then an empty program
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h34, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAB, 0, 1, 8'h00, 16'h1234, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAB, 1, 0, 8'h00, 16'h1234, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hCD, 1, 0, 8'h00, 16'h1234, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h01, 16'hABCD, 1, 1, 0, 0));
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back(mk(0, 1, 8'h42, 1, 0, 8'h01, 16'hABCD, 1, 1, 0, 0));
`endif
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 16'hABCD, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h01, 16'hABCD, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h01, 16'hABCD, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 16'hABCD, 1, 1, 0, 0));
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 16'hABCD, 1, 1, 0, 0));
`endif
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 16'hABCD, 0, 0, 1, 0));

        wq.delete();
        foreach (tbl[i]) begin
            start = tbl[i].st; in_valid = tbl[i].v; in_data = tbl[i].d;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("v%0d_wr_en", i), mem_wr_en, tbl[i].we);
            chk($sformatf("v%0d_addr", i), mem_wr_addr, tbl[i].a);
            chk($sformatf("v%0d_data", i), mem_wr_data, tbl[i].wd);
            chk($sformatf("v%0d_cpu_rst", i), cpu_rst, tbl[i].cpu);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d_done", i), done, tbl[i].dn);
            chk($sformatf("v%0d_error", i), error, tbl[i].er);
            @(posedge clk); #1;
        end
        start = 0; in_valid = 0;
        chk_two_writes("table");

        strm = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
        strm.push_back(8'h42);
`endif
        wq.delete();
        pulse_start();
        send_stream(strm, 1);
        wait_end("toggle", 1, 0);
        chk_two_writes("toggle");

`ifdef LOADER_CHECKSUM_EN
        wq.delete();
        pulse_start();
        send_stream('{8'h01, 8'h55, 8'hAA, 8'h00}, 0);
        wait_end("bad_sum", 0, 1);
        chk("bad_sum_nwr", wq.size(), 1);
        if (wq.size() >= 1) chk("bad_sum_w0", wq[0], 24'h00_55AA);
        pulse_start();
        send_stream('{8'h01, 8'h55, 8'hAA, 8'hFE}, 0);
        wait_end("good_sum", 1, 0);
`endif

        pulse_start();
        send_stream('{8'h02, 8'h12, 8'h34, 8'hAB}, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_cpu_rst", cpu_rst, 1);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_addr", mem_wr_addr, 0);
        chk("midrst_data", mem_wr_data, 0);
        @(posedge clk); #1;
        wq.delete();
        pulse_start();
        send_stream(strm, 0);
        wait_end("after_rst", 1, 0);
        chk_two_writes("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
